// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared states, defaults and control bundles for the pipeline hazard sequencer
package pipe_ctrl_pkg;
   localparam int REG_ADDR_W_DEF = 5;
   typedef enum logic [1:0] {RUN, LU_STALL, DMEM_WAIT, IMEM_WAIT} hz_state_e;
   typedef struct packed {
      logic pc_write_en;
      logic if_id_stall;
      logic if_id_flush;
      logic id_ex_bubble;
      logic ex_mem_hold;
   } pipe_ctrl_t;
   localparam pipe_ctrl_t CTRL_RUN   = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
   localparam pipe_ctrl_t CTRL_DMEM  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
   localparam pipe_ctrl_t CTRL_FLUSH = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
   localparam pipe_ctrl_t CTRL_STALL = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
   localparam pipe_ctrl_t CTRL_RESET = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
endpackage

// File: rtl/haz_detect.sv
// haz_detect: load-use compare between the load in EX and the source regs of the ID instruction
module haz_detect
   import pipe_ctrl_pkg::*;
#(
   parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic                  id_use_rs1,
   input  logic                  id_use_rs2,
   input  logic [REG_ADDR_W-1:0] ex_rd,
   input  logic                  ex_mem_read,
   output logic                  lu
);
   assign lu = ex_mem_read & (ex_rd != '0) &
               ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer; HAZ_PERF_CNT_EN adds lu/flush/mem performance counters
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int REG_ADDR_W = REG_ADDR_W_DEF,
   parameter int WAIT_MAX   = 15
`ifdef HAZ_PERF_CNT_EN
   , parameter int CNT_W    = 32
`endif
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic                  id_use_rs1,
   input  logic                  id_use_rs2,
   input  logic [REG_ADDR_W-1:0] ex_rd,
   input  logic                  ex_mem_read,
   input  logic                  ex_branch_taken,
   input  logic                  imem_ack,
   input  logic                  mem_dreq,
   input  logic                  dmem_ack,
   output logic                  pc_write_en,
   output logic                  if_id_stall,
   output logic                  if_id_flush,
   output logic                  id_ex_bubble,
   output logic                  ex_mem_hold,
   output logic                  fetch_err
`ifdef HAZ_PERF_CNT_EN
   , output logic [CNT_W-1:0]    perf_lu_cnt
   , output logic [CNT_W-1:0]    perf_flush_cnt
   , output logic [CNT_W-1:0]    perf_mem_cnt
`endif
);
   hz_state_e  state, state_n;
   pipe_ctrl_t ctrl;
   logic [7:0] wcnt, wcnt_n;
   logic       lu, c_dmem, c_br, c_lu, c_im;

   haz_detect #(.REG_ADDR_W(REG_ADDR_W)) u_haz_detect (
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .lu(lu)
   );

   // The load has already moved to MEM during LU_STALL, so the same pair must not stall twice.
   always_comb begin
      c_dmem  = mem_dreq & ~dmem_ack;
      c_br    = ~c_dmem & ex_branch_taken;
      c_lu    = ~c_dmem & ~ex_branch_taken & lu & (state != LU_STALL);
      c_im    = ~c_dmem & ~ex_branch_taken & ~c_lu & ~imem_ack;
      ctrl    = reset ? CTRL_RESET : c_dmem ? CTRL_DMEM : c_br ? CTRL_FLUSH :
                (c_lu | c_im) ? CTRL_STALL : CTRL_RUN;
      state_n = c_dmem ? DMEM_WAIT : c_lu ? LU_STALL : c_im ? IMEM_WAIT : RUN;
      wcnt_n  = (c_dmem | c_lu) ? wcnt :
                c_im ? ((wcnt == 8'(WAIT_MAX)) ? wcnt : wcnt + 8'd1) : 8'd0;
   end

   assign pc_write_en  = ctrl.pc_write_en;
   assign if_id_stall  = ctrl.if_id_stall;
   assign if_id_flush  = ctrl.if_id_flush;
   assign id_ex_bubble = ctrl.id_ex_bubble;
   assign ex_mem_hold  = ctrl.ex_mem_hold;

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= RUN;
         wcnt      <= 8'd0;
         fetch_err <= 1'b0;
      end else begin
         state     <= state_n;
         wcnt      <= wcnt_n;
         fetch_err <= fetch_err | (wcnt_n == 8'(WAIT_MAX));
      end
   end

`ifdef HAZ_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_lu_cnt    <= '0;
         perf_flush_cnt <= '0;
         perf_mem_cnt   <= '0;
      end else begin
         perf_lu_cnt    <= perf_lu_cnt + CNT_W'(c_lu);
         perf_flush_cnt <= perf_flush_cnt + CNT_W'(c_br);
         perf_mem_cnt   <= perf_mem_cnt + CNT_W'(c_dmem | c_im);
      end
   end
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: table-driven directed vectors plus multi-cycle hazard sequences
module tb_pipe_hazard_ctrl;
   typedef struct {
      logic       rst;
      logic [4:0] rs1, rs2;
      logic       u1, u2;
      logic [4:0] rd;
      logic       mr, br, ia, dq, da;
      logic [5:0] exp;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
   logic       id_use_rs1 = 1'b0, id_use_rs2 = 1'b0, ex_mem_read = 1'b0;
   logic       ex_branch_taken = 1'b0, imem_ack = 1'b1, mem_dreq = 1'b0, dmem_ack = 1'b0;
   logic       pc_write_en, if_id_stall, if_id_flush, id_ex_bubble, ex_mem_hold, fetch_err;
   int         nvec = 0, nerr = 0;
   vec_t       tbl[18];
`ifdef HAZ_PERF_CNT_EN
   logic [31:0] perf_lu_cnt, perf_flush_cnt, perf_mem_cnt;
`endif

   pipe_hazard_ctrl dut (
      .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
      .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken), .imem_ack(imem_ack),
      .mem_dreq(mem_dreq), .dmem_ack(dmem_ack), .pc_write_en(pc_write_en),
      .if_id_stall(if_id_stall), .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble),
      .ex_mem_hold(ex_mem_hold), .fetch_err(fetch_err)
`ifdef HAZ_PERF_CNT_EN
      , .perf_lu_cnt(perf_lu_cnt), .perf_flush_cnt(perf_flush_cnt), .perf_mem_cnt(perf_mem_cnt)
`endif
   );

   always #5 clk = ~clk;

   function automatic vec_t mkv(input logic rst, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic u1, input logic u2, input logic [4:0] rd,
                                input logic mr, input logic br, input logic ia,
                                input logic dq, input logic da, input logic [5:0] exp);
      vec_t v;
      v.rst = rst; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.rd = rd;
      v.mr = mr; v.br = br; v.ia = ia; v.dq = dq; v.da = da; v.exp = exp;
      return v;
   endfunction

   // Expected bits: {pc_write_en, if_id_stall, if_id_flush, id_ex_bubble, ex_mem_hold, fetch_err}
   task automatic step(input vec_t v, input string name, input int idx);
      logic [5:0] act;
      @(negedge clk);
      reset = v.rst; id_rs1 = v.rs1; id_rs2 = v.rs2; id_use_rs1 = v.u1; id_use_rs2 = v.u2;
      ex_rd = v.rd; ex_mem_read = v.mr; ex_branch_taken = v.br; imem_ack = v.ia;
      mem_dreq = v.dq; dmem_ack = v.da;
      #2;
      act = {pc_write_en, if_id_stall, if_id_flush, id_ex_bubble, ex_mem_hold, fetch_err};
      nvec++;
      if (act !== v.exp || (if_id_stall & if_id_flush)) begin
         nerr++;
         $display("FAIL %s[%0d]: got %b want %b (pc,stall,flush,bubble,hold,ferr)",
                  name, idx, act, v.exp);
      end
   endtask

   initial begin
      tbl[0]  = mkv(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 6'b001100);
      tbl[1]  = mkv(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 6'b100000);
      tbl[2]  = mkv(0, 5, 0, 1, 0, 5, 1, 0, 1, 0, 0, 6'b010100);
      tbl[3]  = mkv(0, 5, 0, 1, 0, 5, 1, 0, 1, 0, 0, 6'b100000);
      tbl[4]  = mkv(0, 0, 0, 1, 0, 0, 1, 0, 1, 0, 0, 6'b100000);
      tbl[5]  = mkv(0, 0, 7, 0, 1, 7, 1, 0, 1, 0, 0, 6'b010100);
      tbl[6]  = mkv(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 6'b100000);
      tbl[7]  = mkv(0, 9, 0, 0, 0, 9, 1, 0, 1, 0, 0, 6'b100000);
      tbl[8]  = mkv(0, 9, 0, 1, 0, 9, 0, 0, 1, 0, 0, 6'b100000);
      tbl[9]  = mkv(0, 5, 0, 1, 0, 5, 1, 1, 0, 0, 0, 6'b101100);
      tbl[10] = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b010100);
      tbl[11] = mkv(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 6'b100000);
      tbl[12] = mkv(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 6'b010010);
      tbl[13] = mkv(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 6'b100000);
      tbl[14] = mkv(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 6'b010010);
      tbl[15] = mkv(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 6'b101100);
      tbl[16] = mkv(0, 3, 0, 1, 0, 3, 1, 0, 1, 1, 0, 6'b010010);
      tbl[17] = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 6'b010010);
      foreach (tbl[i]) step(tbl[i], "tbl", i);
      step(mkv(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 6'b100000), "settle", 0);
      // dmem stall holds a taken branch for three cycles; flush lands with the ack
      for (int i = 0; i < 3; i++) step(mkv(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 6'b010010), "dmem_br", i);
      step(mkv(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 6'b101100), "dmem_br_ack", 0);
      step(mkv(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 6'b100000), "dmem_br_after", 0);
      // imem wait of 20 cycles: fetch_err visible from the 16th stall cycle on
      for (int k = 1; k <= 20; k++)
         step(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, {5'b01010, 1'(k >= 16)}), "imem_wait", k);
      step(mkv(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 6'b100001), "imem_ack_sticky", 0);
      step(mkv(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 6'b101101), "br_sticky", 0);
      for (int k = 0; k < 3; k++) step(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b010101), "rewait", k);
      // reset mid IMEM_WAIT: fetch_err still shows until the reset edge
      step(mkv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b001101), "reset_mid", 0);
      step(mkv(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 6'b100000), "post_reset", 0);
      for (int k = 1; k <= 16; k++)
         step(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, {5'b01010, 1'(k >= 16)}), "wait_after_rst", k);
      step(mkv(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 6'b001101), "final_reset", 0);
      step(mkv(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 6'b100000), "final_run", 0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the five-stage RISC-V pipeline.
- Drives PC write-enable, the IF/ID `stalling` input, IF/ID flush, ID/EX bubble insertion and EX/MEM hold.
- Decisions come from load-use hazards, taken branches in EX, and instruction/data memory ACK handshakes.
- Sits beside the datapath; all pipeline registers take their stall/flush controls only from this block.

Parameters:
- REG_ADDR_W, 5, register index width.
- WAIT_MAX, 15, imem wait cycles tolerated before fetch_err (range 1..255).
- CNT_W, 32, width of the performance counters (optional feature only).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- id_rs1  in  REG_ADDR_W  source reg 1 of the instruction in ID.
- id_rs2  in  REG_ADDR_W  source reg 2 of the instruction in ID.
- id_use_rs1  in  1  ID instruction reads rs1.
- id_use_rs2  in  1  ID instruction reads rs2.
- ex_rd  in  REG_ADDR_W  destination reg of the instruction in EX.
- ex_mem_read  in  1  EX instruction is a load.
- ex_branch_taken  in  1  branch/jump resolved taken in EX.
- imem_ack  in  1  instruction fetch data valid this cycle.
- mem_dreq  in  1  MEM-stage load/store request active.
- dmem_ack  in  1  data memory completes the MEM access.
- pc_write_en  out  1  PC register update enable.
- if_id_stall  out  1  hold IF/ID (drives its `stalling`).
- if_id_flush  out  1  zero IF/ID contents.
- id_ex_bubble  out  1  load NOP into ID/EX.
- ex_mem_hold  out  1  hold EX/MEM and MEM/WB.
- fetch_err  out  1  sticky: imem wait exceeded WAIT_MAX.

Behaviour:
- Reset: clk/reset as already decided — reset is synchronous and active-high, clock is clk.
- While reset is high:
  - state=RUN, wait counter=0, fetch_err=0.
  - pc_write_en=0, if_id_stall=0, if_id_flush=1, id_ex_bubble=1, ex_mem_hold=0.
- Control outputs are combinational from the registered state and the current inputs, so a stall applies in the same cycle as its cause. fetch_err is registered.
- Load-use hazard:
  - lu = ex_mem_read & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
- Priority per cycle, highest first; each later condition is evaluated only if all earlier ones are false:
  - (1) DMEM: mem_dreq & !dmem_ack -> ex_mem_hold=1, if_id_stall=1, pc_write_en=0, id_ex_bubble=0. Whole pipe frozen; no state change except to DMEM_WAIT.
  - (2) BRANCH: ex_branch_taken -> if_id_flush=1, id_ex_bubble=1, pc_write_en=1 (target loads). Overrides lu and imem wait. Counter clears; next state RUN.
  - (3) LOAD-USE: lu -> pc_write_en=0, if_id_stall=1, id_ex_bubble=1, exactly one cycle. Next state LU_STALL. In LU_STALL the load has moved to MEM, so lu is not re-asserted for the same pair. LU_STALL -> RUN unconditionally.
  - (4) IMEM: !imem_ack -> pc_write_en=0, if_id_stall=1, id_ex_bubble=1; next state IMEM_WAIT.
  - (5) Otherwise: pc_write_en=1, all other controls 0.
- States:
  - RUN: normal flow.
  - LU_STALL: one-cycle load-use stall.
  - DMEM_WAIT: exits to RUN on dmem_ack. The cycle carrying dmem_ack is a normal-flow cycle.
  - IMEM_WAIT: exits to RUN on imem_ack.
- Wait counter (8 bits):
  - Increments each IMEM_WAIT cycle and saturates at WAIT_MAX.
  - On reaching WAIT_MAX, fetch_err sets and stays set until reset. The pipeline keeps waiting.
- Simultaneous dmem stall and taken branch: the dmem stall wins. The branch is applied in the cycle dmem_ack arrives, because EX is held and ex_branch_taken remains asserted.
- if_id_stall and if_id_flush are never both 1.

Optional Feature:
- Macro HAZ_PERF_CNT_EN.
- Defined: adds outputs perf_lu_cnt, perf_flush_cnt and perf_mem_cnt, each CNT_W bits.
  - They count cycles spent in cases (3), (2) and (1)+(4) respectively.
  - They wrap at 2^CNT_W and clear on reset.
- Undefined: ports and logic absent; all other behaviour identical.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - hz_state_e enum {RUN, LU_STALL, DMEM_WAIT, IMEM_WAIT};
  - the REG_ADDR_W default;
  - a pipe_ctrl_t struct bundling the five control outputs.
- One natural sub-module: haz_detect, the combinational load-use compare producing lu.

Test Plan:
- lw x5 in EX (ex_mem_read=1, ex_rd=5), ID add uses rs1=5 -> exactly 1 cycle pc_write_en=0, if_id_stall=1, id_ex_bubble=1; following cycle all clear.
- ex_rd=0 with ex_mem_read=1 and id_rs1=0 -> no stall, pc_write_en=1.
- ex_branch_taken=1 while lu=1 and imem_ack=0 -> if_id_flush=1, id_ex_bubble=1, pc_write_en=1, if_id_stall=0.
- mem_dreq=1, dmem_ack low 3 cycles together with ex_branch_taken=1 -> ex_mem_hold=1 and if_id_stall=1 for 3 cycles, flush only in the ack cycle.
- imem_ack low 20 cycles, WAIT_MAX=15 -> fetch_err rises after the 15th wait cycle and stays 1 after the ack; cleared only by reset.
- Reset asserted mid IMEM_WAIT -> next cycle state RUN, fetch_err=0, if_id_flush=1 while reset high.
